button_debounce: RTL and testbench

Conditions the raw push-button pin before it reaches the LED blinker and other control logic. The input is synchronized with a 2-FF chain, polarity is normalized, and the signal is debounced with a counter-qualified FSM. Outputs are a clean level, single-cycle press/release/long-press strobes and a running press counter. It sits directly upstream of the blinker, which uses btn_level / press_pulse in place of the raw pin.

---
 rtl/button_debounce.sv | 200 ++++++++++++++++++++
 tb/tb_button_debounce.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: conditions a raw push-button pin for downstream control logic.
// The pin is synchronized through two flops, normalized so that 1 means pressed,
// and debounced by a counter-qualified FSM. Outputs are a clean level, one-cycle
// press/release/long-press strobes and an 8-bit wrapping press counter.
// Optional feature macro: BUTTON_LONG_PRESS_EN. When it is defined, a long-press
// timer drives long_pulse; when undefined, the timer does not exist, long_pulse
// is tied low and LONG_PRESS_MS has no effect.

module button_debounce #(
    parameter int CLK_F         = 25000000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    // Cycle counts are formed in 64 bits because CLK_F * ms overflows 32 bits.
    localparam longint DB_CYCLES_L = (longint'(CLK_F) * longint'(DEBOUNCE_MS)) / longint'(1000);
    localparam int     DB_CYCLES   = int'(DB_CYCLES_L);
    localparam int     DB_W        = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_FIRST = DB_W'(1);
    // With a one-cycle debounce the first qualifying sample already completes the check.
    localparam bit     DB_SINGLE   = (DB_CYCLES == 1);
    // Pin level that means "released"; the sync flops reset to it.
    localparam logic   RELEASED_PIN = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        REL_CHK
    } state_t;

    state_t          r_state;
    state_t          w_stateNxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_btnS;
    logic [DB_W-1:0] r_dbCnt;
    logic [DB_W-1:0] w_dbCntNxt;
    logic            w_level;
    logic            w_pressNxt;
    logic            w_releaseNxt;
    logic            w_longNxt;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic [7:0]      r_pressCount;

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= RELEASED_PIN;
            r_sync2 <= RELEASED_PIN;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btnS = r_sync2 ^ RELEASED_PIN;

    // State register and debounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dbCnt <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_dbCnt <= w_dbCntNxt;
        end
    end

    // Next-state logic: a change is accepted only after DB_CYCLES consecutive samples
    always_comb begin
        w_stateNxt = r_state;
        w_dbCntNxt = r_dbCnt;
        unique case (r_state)
            IDLE: begin
                if (w_btnS) begin
                    if (DB_SINGLE) begin
                        w_stateNxt = PRESSED;
                        w_dbCntNxt = '0;
                    end else begin
                        w_stateNxt = PRESS_CHK;
                        w_dbCntNxt = DB_FIRST;
                    end
                end else begin
                    w_dbCntNxt = '0;
                end
            end
            PRESS_CHK: begin
                if (!w_btnS) begin
                    w_stateNxt = IDLE;
                    w_dbCntNxt = '0;
                end else if (r_dbCnt == DB_LAST) begin
                    w_stateNxt = PRESSED;
                    w_dbCntNxt = '0;
                end else begin
                    w_dbCntNxt = r_dbCnt + DB_FIRST;
                end
            end
            PRESSED: begin
                if (!w_btnS) begin
                    if (DB_SINGLE) begin
                        w_stateNxt = IDLE;
                        w_dbCntNxt = '0;
                    end else begin
                        w_stateNxt = REL_CHK;
                        w_dbCntNxt = DB_FIRST;
                    end
                end else begin
                    w_dbCntNxt = '0;
                end
            end
            REL_CHK: begin
                if (w_btnS) begin
                    w_stateNxt = PRESSED;
                    w_dbCntNxt = '0;
                end else if (r_dbCnt == DB_LAST) begin
                    w_stateNxt = IDLE;
                    w_dbCntNxt = '0;
                end else begin
                    w_dbCntNxt = r_dbCnt + DB_FIRST;
                end
            end
            default: begin
                w_stateNxt = IDLE;
                w_dbCntNxt = '0;
            end
        endcase
    end

    // Output decode: level from state, strobes from accepted transitions
    always_comb begin
        w_level      = (r_state == PRESSED) || (r_state == REL_CHK);
        w_pressNxt   = !w_level && (w_stateNxt == PRESSED);
        w_releaseNxt = w_level && (w_stateNxt == IDLE);
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam longint LP_CYCLES_L = (longint'(CLK_F) * longint'(LONG_PRESS_MS)) / longint'(1000);
    localparam int     LP_CYCLES   = int'(LP_CYCLES_L);
    localparam int     LP_W        = $clog2(LP_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_FULL = LP_W'(LP_CYCLES);
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

    logic [LP_W-1:0] r_lpCnt;

    // Long-press timer: restarts on each accepted press, runs while held (including release checks), saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lpCnt <= '0;
        end else if (w_pressNxt) begin
            r_lpCnt <= '0;
        end else if (w_level && (r_lpCnt != LP_FULL)) begin
            r_lpCnt <= r_lpCnt + LP_ONE;
        end
    end

    // Fires once as the timer reaches its limit; an accepted release on the same edge wins
    assign w_longNxt = w_level && !w_releaseNxt && (r_lpCnt == LP_LAST);
`else
    assign w_longNxt = 1'b0;
`endif

    // Registered strobes and the wrapping press counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long       <= 1'b0;
            r_pressCount <= 8'd0;
        end else begin
            r_press   <= w_pressNxt;
            r_release <= w_releaseNxt;
            r_long    <= w_longNxt;
            if (w_pressNxt) begin
                r_pressCount <= r_pressCount + 8'd1;
            end
        end
    end

    assign btn_level     = w_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign press_count   = r_pressCount;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: drives button_debounce with directed and random pin
// patterns and compares every cycle against a behavioural model that tracks
// how long the synchronized pin has disagreed with the debounced level.

module tb_button_debounce;

    localparam int DB = 4;
    localparam int LP = 10;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       button;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int nTests;
    int nFails;
    int nPressSeen;
    int nReleaseSeen;
    int nLongSeen;

    // Model state: pressed-samples of the pin, one and two edges old
    logic [1:0] mDelay;
    logic       mLevel;
    int         mRun;
    int         mHeld;
    logic [7:0] mCount;
    logic       mPress;
    logic       mRelease;
    logic       mLong;

    button_debounce #(
        .CLK_F        (1000),
        .DEBOUNCE_MS  (4),
        .LONG_PRESS_MS(10),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nTests++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        mDelay   = 2'b00;
        mLevel   = 1'b0;
        mRun     = 0;
        mHeld    = 0;
        mCount   = 8'd0;
        mPress   = 1'b0;
        mRelease = 1'b0;
        mLong    = 1'b0;
    endtask

    // One rising edge: the level flips after DB consecutive disagreeing samples
    task automatic modelStep(input logic pinVal);
        logic sNow;
        sNow   = mDelay[1];
        mDelay = {mDelay[0], ~pinVal};
        mPress   = 1'b0;
        mRelease = 1'b0;
        mLong    = 1'b0;
        if (mLevel && mHeld <= LP) mHeld++;
        if (sNow != mLevel) mRun++;
        else mRun = 0;
        if (mRun == DB) begin
            mRun   = 0;
            mLevel = !mLevel;
            if (mLevel) begin
                mPress = 1'b1;
                mCount = mCount + 8'd1;
                mHeld  = 0;
            end else begin
                mRelease = 1'b1;
            end
        end
        if (LONG_EN && mLevel && !mPress && mHeld == LP) mLong = 1'b1;
    endtask

    task automatic compareAll();
        checkOutput("btn_level",     int'(btn_level),     int'(mLevel));
        checkOutput("press_pulse",   int'(press_pulse),   int'(mPress));
        checkOutput("release_pulse", int'(release_pulse), int'(mRelease));
        checkOutput("long_pulse",    int'(long_pulse),    int'(mLong));
        checkOutput("press_count",   int'(press_count),   int'(mCount));
    endtask

    // Drive one pin value for one clock, then compare after the edge; returns at the next negedge
    task automatic applyStimulus(input logic pinVal);
        button = pinVal;
        @(posedge clk);
        #1;
        modelStep(pinVal);
        compareAll();
        nPressSeen   += int'(press_pulse);
        nReleaseSeen += int'(release_pulse);
        nLongSeen    += int'(long_pulse);
        @(negedge clk);
    endtask

    // Assert reset between edges, check the immediate clear, hold it over two edges
    task automatic applyReset();
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset_level_now", int'(btn_level), 0);
        checkOutput("reset_count_now", int'(press_count), 0);
        compareAll();
        repeat (2) begin
            @(posedge clk);
            #1;
            compareAll();
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic clearSeen();
        nPressSeen   = 0;
        nReleaseSeen = 0;
        nLongSeen    = 0;
    endtask

    initial begin
        logic [9:0] bounce;
        logic       rVal;
        int         rLen;

        nTests = 0;
        nFails = 0;
        clearSeen();
        modelReset();
        rst    = 1'b0;
        button = 1'b1;
        @(negedge clk);

        // Reset, then idle with the pin released
        applyReset();
        repeat (50) applyStimulus(1'b1);
        checkOutput("idle_level", int'(btn_level), 0);
        checkOutput("idle_count", int'(press_count), 0);

        // Bounce never stable for four samples
        clearSeen();
        bounce = 10'b0010001101;
        for (int i = 9; i >= 0; i--) applyStimulus(bounce[i]);
        repeat (10) applyStimulus(1'b1);
        checkOutput("bounce_presses", nPressSeen, 0);
        checkOutput("bounce_level", int'(btn_level), 0);
        checkOutput("bounce_count", int'(press_count), 0);

        // Clean press and release
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0);
            if (i == 5) checkOutput("clean_press_early", int'(press_pulse), 0);
            if (i == 6) begin
                checkOutput("clean_press_pulse", int'(press_pulse), 1);
                checkOutput("clean_press_level", int'(btn_level), 1);
                checkOutput("clean_press_count", int'(press_count), 1);
            end
            if (i == 7) checkOutput("clean_press_width", int'(press_pulse), 0);
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1);
            if (i == 5) begin
                checkOutput("clean_release_early", int'(release_pulse), 0);
                checkOutput("clean_release_hold", int'(btn_level), 1);
            end
            if (i == 6) begin
                checkOutput("clean_release_pulse", int'(release_pulse), 1);
                checkOutput("clean_release_level", int'(btn_level), 0);
            end
            if (i == 7) checkOutput("clean_release_width", int'(release_pulse), 0);
        end

        // Long hold with a short release glitch in the middle
        clearSeen();
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0);
            if (i == 15) checkOutput("long_early", int'(long_pulse), 0);
            if (i == 16) checkOutput("long_pulse_at", int'(long_pulse), int'(LONG_EN));
        end
        repeat (2) applyStimulus(1'b1);
        repeat (10) applyStimulus(1'b0);
        checkOutput("glitch_no_release", nReleaseSeen, 0);
        repeat (8) applyStimulus(1'b1);
        checkOutput("long_once", nLongSeen, int'(LONG_EN));
        checkOutput("long_releases", nReleaseSeen, 1);
        checkOutput("long_count", int'(press_count), 2);

        // Random bursts, occasionally long enough to reach a long press
        for (int b = 0; b < 250; b++) begin
            rVal = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rLen = int'($urandom_range(10, 25));
            else rLen = int'($urandom_range(1, 6));
            repeat (rLen) applyStimulus(rVal);
        end
        repeat (10) applyStimulus(1'b1);

        // Reset while pressed: no release, pin still held is requalified
        repeat (8) applyStimulus(1'b0);
        checkOutput("midreset_pressed", int'(btn_level), 1);
        clearSeen();
        applyReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0);
            if (i == 5) checkOutput("repress_early", int'(press_pulse), 0);
            if (i == 6) begin
                checkOutput("repress_pulse", int'(press_pulse), 1);
                checkOutput("repress_count", int'(press_count), 1);
            end
        end
        checkOutput("midreset_no_release", nReleaseSeen, 0);
        repeat (8) applyStimulus(1'b1);

        // Counter wrap over 256 presses
        applyReset();
        for (int p = 1; p <= 256; p++) begin
            repeat (7) applyStimulus(1'b0);
            if (p == 255) checkOutput("wrap_255", int'(press_count), 255);
            if (p == 256) checkOutput("wrap_0", int'(press_count), 0);
            repeat (7) applyStimulus(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
